// File: rtl/dma_copy_pkg.sv
// Shared types and constants for the dma_copy_master memory-to-memory copy engine.
package dma_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BE_ALL     = 4'hF;

endpackage

// File: rtl/dma_copy_fifo.sv
// Synchronous read-data FIFO; the head is a registered slot, so a push becomes
// visible on head the cycle after it is written (no fall-through).
module dma_copy_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and count define validity, and a reset RAM would cost a flop
  // per bit instead of mapping onto memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register in this block sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/dma_copy_master.sv
// Avalon-MM copy engine: reads len_words words from src_addr into a small FIFO
// and writes them out to dst_addr, with a start/busy/done handshake.
module dma_copy_master
  import dma_copy_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_read,
  input  logic              rd_waitrequest,
  input  logic [31:0]       rd_readdata,
  input  logic              rd_readdatavalid,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_write,
  output logic [31:0]       wr_writedata,
  output logic [3:0]        wr_byteenable,
  input  logic              wr_waitrequest
);

  localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WORD_BYTES);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rd_addr_q, wr_addr_q;
  logic [LEN_W-1:0]   rd_remaining_q, wr_remaining_q;
  logic [CNT_W-1:0]   outstanding_q;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, fifo_full;
  logic               in_run, rd_accept, wr_accept, push;

  assign in_run    = (state_q == RUN);
  assign push      = in_run & rd_readdatavalid;
  assign rd_accept = rd_read & ~rd_waitrequest;
  assign wr_accept = wr_write & ~wr_waitrequest;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len_words == '0) ? DONE : RUN;
      RUN:     if (wr_accept && wr_remaining_q == LEN_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads in flight plus buffered words never exceed the FIFO, so a return
  // always has a free slot to land in.
  always_comb begin
    rd_read  = in_run && (rd_remaining_q != '0) &&
               (({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CNT_W + 1)'(FIFO_DEPTH));
    wr_write = in_run && !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rd_addr_q      <= '0;
      wr_addr_q      <= '0;
      rd_remaining_q <= '0;
      wr_remaining_q <= '0;
      outstanding_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        rd_addr_q      <= src_addr & ALIGN_MASK;
        wr_addr_q      <= dst_addr & ALIGN_MASK;
        rd_remaining_q <= len_words;
        wr_remaining_q <= len_words;
        outstanding_q  <= '0;
      end else begin
        if (rd_accept) begin
          rd_addr_q      <= rd_addr_q + ADDR_STEP;
          rd_remaining_q <= rd_remaining_q - LEN_W'(1);
        end
        if (wr_accept) begin
          wr_addr_q      <= wr_addr_q + ADDR_STEP;
          wr_remaining_q <= wr_remaining_q - LEN_W'(1);
        end
        case ({rd_accept, push})
          2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
          2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
          default: outstanding_q <= outstanding_q;
        endcase
      end
    end
  end

  dma_copy_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (rd_readdata),
    .pop       (wr_accept),
    .head      (wr_writedata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign busy          = in_run;
  assign done          = (state_q == DONE);
  assign rd_address    = rd_addr_q;
  assign wr_address    = wr_addr_q;
  assign wr_byteenable = BE_ALL;

  no_fifo_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && fifo_full));

endmodule

// File: tb/tb_dma_copy_master.sv
// Randomized bench for dma_copy_master against a transaction-level model of the
// copy: expected address/data streams, request rules and completion timing.
module tb_dma_copy_master;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len_words;
  logic        busy, done;
  logic [31:0] rd_address;
  logic        rd_read, rd_waitrequest;
  logic [31:0] rd_readdata;
  logic        rd_readdatavalid;
  logic [31:0] wr_address;
  logic        wr_write;
  logic [31:0] wr_writedata;
  logic [3:0]  wr_byteenable;
  logic        wr_waitrequest;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] src_mem [logic [31:0]];

  dma_copy_master #(
    .ADDR_W     (32),
    .LEN_W      (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .len_words        (len_words),
    .busy             (busy),
    .done             (done),
    .rd_address       (rd_address),
    .rd_read          (rd_read),
    .rd_waitrequest   (rd_waitrequest),
    .rd_readdata      (rd_readdata),
    .rd_readdatavalid (rd_readdatavalid),
    .wr_address       (wr_address),
    .wr_write         (wr_write),
    .wr_writedata     (wr_writedata),
    .wr_byteenable    (wr_byteenable),
    .wr_waitrequest   (wr_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One copy driven from IDLE; start is presented in cycle 0. exp_done/exp_max
  // of -1 skip those checks, ign_cyc pulses a stray start, abort_after returns
  // mid-run once that many writes have been accepted.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int lat, input int wait_pct, input int exp_done,
                          input int ign_cyc, input int abort_after, input int exp_max);
    int          reads, writes, returned, max_inflight, cyc;
    bit          finished, prev_rd_stall, prev_wr_stall;
    logic [31:0] prev_rd_addr, prev_wr_addr, prev_wr_data, a;
    rsp_t        r;
    reads = 0; writes = 0; returned = 0; max_inflight = 0;
    finished = 1'b0; prev_rd_stall = 1'b0; prev_wr_stall = 1'b0;
    prev_rd_addr = '0; prev_wr_addr = '0; prev_wr_data = '0;
    for (int i = 0; i < len; i++) begin
      a = src + 32'(4 * i);
      src_mem[a] = $urandom;
    end
    src_addr  = src;
    dst_addr  = dst;
    len_words = 16'(len);
    start     = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!finished && cyc < 2000) begin
      if (done) begin
        check("done_busy", 32'(busy), 32'd0);
        check("done_rd_read", 32'(rd_read), 32'd0);
        check("done_wr_write", 32'(wr_write), 32'd0);
        check("read_count", reads, len);
        check("write_count", writes, len);
        if (exp_done >= 0) check("done_cycle", cyc, exp_done);
        if (exp_max >= 0) check("max_inflight", max_inflight, exp_max);
        else check("inflight_bound", 32'(max_inflight <= DEPTH), 32'd1);
        rd_readdatavalid = 1'b0;
        rd_waitrequest   = 1'b0;
        wr_waitrequest   = 1'b0;
        start     = 1'b1;
        src_addr  = 32'h0;
        len_words = 16'd5;
        tick();
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("start_in_done_ignored", 32'(busy), 32'd0);
        finished = 1'b1;
      end else begin
        check("busy", 32'(busy), 32'd1);
        check("rd_read_rule", 32'(rd_read), 32'((reads < len) && (reads - writes < DEPTH)));
        check("wr_write_rule", 32'(wr_write), 32'(returned > writes));
        if (prev_rd_stall) begin
          check("rd_read_held", 32'(rd_read), 32'd1);
          check("rd_addr_stable", rd_address, prev_rd_addr);
        end
        if (prev_wr_stall) begin
          check("wr_write_held", 32'(wr_write), 32'd1);
          check("wr_addr_stable", wr_address, prev_wr_addr);
          check("wr_data_stable", wr_writedata, prev_wr_data);
        end
        if (reads - writes > max_inflight) max_inflight = reads - writes;

        start = (cyc == ign_cyc);
        if (start) begin
          src_addr  = 32'h40;
          dst_addr  = 32'h80;
          len_words = 16'd7;
        end
        rd_waitrequest = ($urandom_range(99) < wait_pct);
        wr_waitrequest = ($urandom_range(99) < wait_pct);
        if (rq.size() > 0 && rq[0].due == cyc) begin
          rd_readdatavalid = 1'b1;
          rd_readdata      = rq[0].data;
          void'(rq.pop_front());
          returned++;
        end else begin
          rd_readdatavalid = 1'b0;
          rd_readdata      = $urandom;
        end

        if (rd_read && !rd_waitrequest) begin
          check("rd_address", rd_address, src + 32'(4 * reads));
          r.data = src_mem.exists(rd_address) ? src_mem[rd_address] : 32'hDEAD_BEEF;
          r.due  = cyc + lat;
          rq.push_back(r);
          reads++;
        end
        if (wr_write && !wr_waitrequest) begin
          a = src + 32'(4 * writes);
          check("wr_address", wr_address, dst + 32'(4 * writes));
          check("wr_data", wr_writedata, src_mem[a]);
          check("wr_byteenable", 32'(wr_byteenable), 32'hF);
          writes++;
        end
        prev_rd_stall = rd_read && rd_waitrequest;
        prev_wr_stall = wr_write && wr_waitrequest;
        prev_rd_addr  = rd_address;
        prev_wr_addr  = wr_address;
        prev_wr_data  = wr_writedata;

        if (abort_after > 0 && writes == abort_after) begin
          finished = 1'b1;
        end else begin
          tick();
          cyc++;
        end
      end
    end
    if (!finished) check("timeout", 32'd1, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_read"}, 32'(rd_read), 32'd0);
    check({tag, "_wr_write"}, 32'(wr_write), 32'd0);
    check({tag, "_rd_address"}, rd_address, 32'd0);
    check({tag, "_wr_address"}, wr_address, 32'd0);
    check({tag, "_byteenable"}, 32'(wr_byteenable), 32'hF);
  endtask

  initial begin
    reset_n          = 1'b0;
    start            = 1'b0;
    src_addr         = '0;
    dst_addr         = '0;
    len_words        = '0;
    rd_waitrequest   = 1'b0;
    rd_readdata      = '0;
    rd_readdatavalid = 1'b0;
    wr_waitrequest   = 1'b0;
    repeat (2) tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Basic zero-wait copy: done at cycle 3+N.
    run_copy(32'h0000_0000, 32'h0000_1000, 4, 1, 0, 7, -1, 0, -1);
    // Zero length: done at cycle 1, no traffic, never busy.
    run_copy(32'h0000_0200, 32'h0000_1200, 0, 1, 0, 1, -1, 0, -1);
    // Back-pressure on both ports.
    run_copy(32'h0000_0400, 32'h0000_2000, 16, 1, 50, -1, -1, 0, -1);
    // Slow reads fill the whole in-flight budget.
    run_copy(32'h0000_0100, 32'h0000_3000, 8, 3, 0, -1, -1, 0, DEPTH);
    // Address wrap with a stray start during RUN.
    run_copy(32'hFFFF_FFF8, 32'h0000_2000, 4, 1, 0, 7, 2, 0, -1);

    // Reset after 5 of 16 words, then a late return while idle.
    run_copy(32'h0000_0800, 32'h0000_4000, 16, 2, 30, -1, -1, 5, -1);
    reset_n          = 1'b0;
    rd_readdatavalid = 1'b0;
    rd_waitrequest   = 1'b0;
    wr_waitrequest   = 1'b0;
    tick();
    check_idle_outputs("midreset");
    reset_n = 1'b1;
    rq.delete();
    rd_readdatavalid = 1'b1;
    rd_readdata      = 32'hBAD0_BAD0;
    tick();
    rd_readdatavalid = 1'b0;
    tick();
    check("late_rvalid_ignored", 32'(wr_write), 32'd0);
    check("late_rvalid_idle", 32'(busy), 32'd0);
    run_copy(32'h0000_0C00, 32'h0000_5000, 2, 1, 0, 5, -1, 0, -1);

    // Randomized copies.
    for (int k = 0; k < 4; k++) begin
      run_copy($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               int'($urandom_range(20, 1)), int'($urandom_range(3, 1)), 25, -1, -1, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
